// File: rtl/cache_pkg.sv
// Shared cache encodings and geometry, reused by the data and instruction caches.
package cache_pkg;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);
  localparam int BLOCK_W        = WORDS_PER_LINE * 32;
  localparam int MEM_ADDR_W     = 28;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2,
    UPDATE     = 2'd3
  } cache_state_t;
endpackage

// File: rtl/data_cache_controller_if.sv
// Memory-side block bus between the data cache (master) and backing memory (slave).
interface data_cache_controller_if;
  logic                            MEM_READ;
  logic                            MEM_WRITE;
  logic [cache_pkg::MEM_ADDR_W-1:0] MEM_ADDRESS;
  logic [cache_pkg::BLOCK_W-1:0]    MEM_WRITE_DATA;
  logic [cache_pkg::BLOCK_W-1:0]    MEM_READ_DATA;
  logic                            MEM_BUSY_WAIT;

  modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA,
                  input  MEM_READ_DATA, MEM_BUSY_WAIT);
  modport slave  (input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA,
                  output MEM_READ_DATA, MEM_BUSY_WAIT);
endinterface

// File: rtl/data_cache_align.sv
// Load extraction (sign/zero extend) and store byte-lane merge for one cache block.
module data_cache_align
  import cache_pkg::*;
(
  input  logic [BLOCK_W-1:0]  block,
  input  logic [OFFSET_W-1:0] word_sel,
  input  logic [1:0]          lane,
  input  logic [2:0]          funct3,
  input  logic [1:0]          store_type,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [BLOCK_W-1:0]  merged
);
  logic [31:0] word;
  logic [31:0] new_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    word   = block[{word_sel, 5'b0} +: 32];
    byte_v = word[{lane, 3'b0} +: 8];
    half_v = word[{lane[1], 4'b0} +: 16];

    case (funct3)
      F3_LB:   rdata = {{24{byte_v[7]}}, byte_v};
      F3_LH:   rdata = {{16{half_v[15]}}, half_v};
      F3_LW:   rdata = word;
      F3_LBU:  rdata = {24'b0, byte_v};
      F3_LHU:  rdata = {16'b0, half_v};
      default: rdata = '0;
    endcase

    new_word = word;
    case (store_type)
      ST_SB:   new_word[{lane, 3'b0} +: 8]     = wdata[7:0];
      ST_SH:   new_word[{lane[1], 4'b0} +: 16] = wdata[15:0];
      ST_SW:   new_word = wdata;
      default: new_word = word;
    endcase

    merged = block;
    merged[{word_sel, 5'b0} +: 32] = new_word;
  end
endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with a 4-word line.
//
// state      | meaning
// IDLE       | serve hits combinationally; detect miss and pick victim path
// WRITE_BACK | push dirty victim block to memory
// ALLOCATE   | fetch requested block from memory
// UPDATE     | install fetched block, then the held request hits in IDLE
module data_cache_controller
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  memReadEn,
  input  logic [2:0]  memWriteEn,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT,
  data_cache_controller_if.master mem
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  cache_state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];
  logic [BLOCK_W-1:0]   fill_q;

  logic [OFFSET_W-1:0] offset;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                store_req, load_req, req, hit;
  logic [31:0]         load_word;
  logic [BLOCK_W-1:0]  merged;

  assign offset    = ADDRESS[3:2];
  assign idx       = ADDRESS[4 +: IDX_W];
  assign tag       = ADDRESS[31 -: TAG_W];
  // Simultaneous load and store enables resolve to a store.
  assign store_req = memWriteEn[2];
  assign load_req  = memReadEn[3] & ~store_req;
  assign req       = load_req | store_req;
  assign hit       = (state == IDLE) & req & valid_q[idx] & (tag_q[idx] == tag);
  assign READ_DATA = (hit & load_req) ? load_word : '0;
  assign BUSY_WAIT = (req & ~hit) | (state != IDLE);

  data_cache_align u_align (
    .block      (data_q[idx]),
    .word_sel   (offset),
    .lane       (ADDRESS[1:0]),
    .funct3     (memReadEn[2:0]),
    .store_type (memWriteEn[1:0]),
    .wdata      (WRITE_DATA),
    .rdata      (load_word),
    .merged     (merged)
  );

  always_comb begin
    state_nxt          = state;
    mem.MEM_READ       = 1'b0;
    mem.MEM_WRITE      = 1'b0;
    mem.MEM_ADDRESS    = '0;
    mem.MEM_WRITE_DATA = '0;
    case (state)
      IDLE: begin
        if (req && !hit)
          state_nxt = (valid_q[idx] && dirty_q[idx]) ? WRITE_BACK : ALLOCATE;
      end
      WRITE_BACK: begin
        mem.MEM_WRITE      = 1'b1;
        mem.MEM_ADDRESS    = {tag_q[idx], idx};
        mem.MEM_WRITE_DATA = data_q[idx];
        if (!mem.MEM_BUSY_WAIT) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        mem.MEM_READ    = 1'b1;
        mem.MEM_ADDRESS = ADDRESS[31:4];
        if (!mem.MEM_BUSY_WAIT) state_nxt = UPDATE;
      end
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == UPDATE) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (hit && store_req) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (state == ALLOCATE && !mem.MEM_BUSY_WAIT) fill_q <= mem.MEM_READ_DATA;
    if (!RESET) begin
      if (state == UPDATE) begin
        data_q[idx] <= fill_q;
        tag_q[idx]  <= tag;
      end else if (hit && store_req) begin
        data_q[idx] <= merged;
      end
    end
  end
endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench: stimulus queues expected CPU and memory-bus results, monitors compare.
module tb_data_cache_controller;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  rd_en = '0;
  logic [2:0]  wr_en = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;

  localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101;
  localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110;

  data_cache_controller_if mif();

  data_cache_controller #(.NUM_LINES(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .memReadEn  (rd_en),
    .memWriteEn (wr_en),
    .ADDRESS    (addr),
    .WRITE_DATA (wdata),
    .READ_DATA  (READ_DATA),
    .BUSY_WAIT  (BUSY_WAIT),
    .mem        (mif)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  typedef struct { logic [31:0] rdata; int stalls; string name; } cpu_exp_t;
  typedef struct { logic wr; logic [27:0] maddr; logic [127:0] data; string name; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  // Backing memory with a programmable strobe latency.
  logic [127:0] mem_blk [256];
  logic         mem_init = 1'b1;
  int           lat = 2;
  int           cnt = 0;
  wire strobe   = mif.MEM_READ | mif.MEM_WRITE;
  wire mem_busy = strobe && (cnt < lat);
  wire cpu_req  = rd_en[3] | wr_en[2];
  assign mif.MEM_BUSY_WAIT = mem_busy;
  assign mif.MEM_READ_DATA = mem_blk[mif.MEM_ADDRESS[7:0]];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_blk[i] <= '0;
      mem_blk[8'h04] <= {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};
      mem_blk[8'h0C] <= {32'h0C0C_0003, 32'h0C0C_0002, 32'h0C0C_0001, 32'hCAFE_F00D};
      mem_blk[8'h08] <= {32'h0, 32'h0, 32'h5555_AAAA, 32'h0};
    end else if (strobe && !mem_busy) begin
      if (mif.MEM_WRITE) mem_blk[mif.MEM_ADDRESS[7:0]] <= mif.MEM_WRITE_DATA;
    end
    if (strobe && !mem_busy) cnt <= 0;
    else if (strobe)         cnt <= cnt + 1;
    else                     cnt <= 0;
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_expect(string name, logic wr, logic [27:0] a, logic [127:0] d);
    mem_exp_t e;
    e.name = name; e.wr = wr; e.maddr = a; e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic cpu_op(string name, logic [3:0] r, logic [2:0] w, logic [31:0] a,
                        logic [31:0] d, logic [31:0] exp_rd, int exp_st);
    cpu_exp_t e;
    int n;
    e.name = name; e.rdata = exp_rd; e.stalls = exp_st;
    cpu_q.push_back(e);
    rd_en = r; wr_en = w; addr = a; wdata = d;
    n = 0;
    @(negedge CLK);
    while (BUSY_WAIT && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY_WAIT) begin
      total++; bad++;
      $display("FAIL %s_timeout: BUSY_WAIT high after %0d cycles, required low", name, n);
    end
    @(posedge CLK); #1;
    rd_en = '0; wr_en = '0;
  endtask

  // CPU-side monitor: counts stall cycles and checks READ_DATA on completion.
  initial begin : cpu_mon
    cpu_exp_t ce;
    int stalls;
    stalls = 0;
    forever @(negedge CLK) begin
      if (RESET || !cpu_req) stalls = 0;
      else if (BUSY_WAIT) stalls++;
      else begin
        if (cpu_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cpu_unexpected: completion at addr %h with nothing expected", addr);
        end else begin
          ce = cpu_q.pop_front();
          chk({ce.name, "_rdata"}, READ_DATA, ce.rdata);
          chk({ce.name, "_stalls"}, stalls, ce.stalls);
        end
        stalls = 0;
      end
    end
  end

  // Memory-side monitor: address stability, strobe exclusivity, accepted transfers.
  initial begin : mem_mon
    mem_exp_t me;
    logic in_txn;
    logic [27:0] hold;
    in_txn = 1'b0;
    hold = '0;
    forever @(negedge CLK) begin
      if (strobe) begin
        if (in_txn) chk("mem_addr_stable", mif.MEM_ADDRESS, hold);
        else begin
          in_txn = 1'b1;
          hold = mif.MEM_ADDRESS;
        end
        chk("mem_strobe_excl", mif.MEM_READ & mif.MEM_WRITE, 0);
        if (!mem_busy) begin
          if (mem_q.size() == 0) begin
            total++; bad++;
            $display("FAIL mem_unexpected: wr=%0d addr %h with nothing expected",
                     mif.MEM_WRITE, mif.MEM_ADDRESS);
          end else begin
            me = mem_q.pop_front();
            chk({me.name, "_kind"}, mif.MEM_WRITE, me.wr);
            chk({me.name, "_addr"}, mif.MEM_ADDRESS, me.maddr);
            if (me.wr) chk({me.name, "_wdata"}, mif.MEM_WRITE_DATA, me.data);
          end
          in_txn = 1'b0;
        end
      end else begin
        in_txn = 1'b0;
      end
    end
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    mem_init = 1'b0;
    @(negedge CLK);
    chk("rst_mem_read", mif.MEM_READ, 0);
    chk("rst_mem_write", mif.MEM_WRITE, 0);
    chk("rst_mem_addr", mif.MEM_ADDRESS, 0);
    chk("rst_mem_wdata", mif.MEM_WRITE_DATA, 0);
    chk("rst_busy", BUSY_WAIT, 0);
    chk("rst_rdata", READ_DATA, 0);
    @(posedge CLK); #1;

    mem_expect("alloc40", 1'b0, 28'h4, '0);
    cpu_op("lw40", LW, 3'b0, 32'h40, 32'h0, 32'h1234_5678, 5);
    cpu_op("sb41", 4'b0, SB, 32'h41, 32'h1234_56AB, 32'h0, 0);
    cpu_op("lb41", LB, 3'b0, 32'h41, 32'h0, 32'hFFFF_FFAB, 0);
    cpu_op("lbu41", LBU, 3'b0, 32'h41, 32'h0, 32'h0000_00AB, 0);
    cpu_op("lh43", LH, 3'b0, 32'h43, 32'h0, 32'h0000_1234, 0);
    cpu_op("sh46", 4'b0, SH, 32'h46, 32'h0000_8001, 32'h0, 0);
    cpu_op("lh47", LH, 3'b0, 32'h47, 32'h0, 32'hFFFF_8001, 0);
    cpu_op("lhu46", LHU, 3'b0, 32'h46, 32'h0, 32'h0000_8001, 0);
    cpu_op("lw45", LW, 3'b0, 32'h45, 32'h0, 32'h8001_0001, 0);
    cpu_op("both48", LW, SW, 32'h48, 32'hDEAD_BEEF, 32'h0, 0);

    mem_expect("wb04", 1'b1, 28'h4,
               {32'hDDDD_0003, 32'hDEAD_BEEF, 32'h8001_0001, 32'h1234_AB78});
    mem_expect("allocC0", 1'b0, 28'hC, '0);
    cpu_op("lwC0", LW, 3'b0, 32'hC0, 32'h0, 32'hCAFE_F00D, 8);

    mem_expect("alloc48", 1'b0, 28'h4, '0);
    cpu_op("lw48", LW, 3'b0, 32'h48, 32'h0, 32'hDEAD_BEEF, 5);

    lat = 5;
    mem_expect("alloc84", 1'b0, 28'h8, '0);
    cpu_op("lw84_slow", LW, 3'b0, 32'h84, 32'h0, 32'h5555_AAAA, 8);
    lat = 2;

    cpu_op("sb40_dirty", 4'b0, SB, 32'h40, 32'h0000_0077, 32'h0, 0);

    lat = 10;
    rd_en = LW; addr = 32'h100;
    n = 0;
    @(negedge CLK);
    while (!mif.MEM_READ && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("rstmid_saw_alloc", mif.MEM_READ, 1);
    @(negedge CLK);
    RESET = 1'b1;
    rd_en = '0;
    @(negedge CLK);
    chk("rstmid_mem_read", mif.MEM_READ, 0);
    chk("rstmid_mem_write", mif.MEM_WRITE, 0);
    chk("rstmid_busy", BUSY_WAIT, 0);
    RESET = 1'b0;
    lat = 2;
    @(posedge CLK); #1;

    mem_expect("alloc40_again", 1'b0, 28'h4, '0);
    cpu_op("lw40_again", LW, 3'b0, 32'h40, 32'h0, 32'h1234_AB78, 5);
    mem_expect("allocC0_again", 1'b0, 28'hC, '0);
    cpu_op("lwC0_again", LW, 3'b0, 32'hC0, 32'h0, 32'hCAFE_F00D, 5);

    repeat (3) @(negedge CLK);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_cache_controller.md
DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 The block SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port memReadEn  in  4  bit3 = load request; bits[2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-005 The block SHALL have port memWriteEn  in  3  bit2 = store request; bits[1:0] = 00 SB, 01 SH, 10 SW.
REQ-006 The block SHALL have port ADDRESS  in  32  byte address of the CPU access.
REQ-007 The block SHALL have port WRITE_DATA  in  32  store data, right-aligned.
REQ-008 The block SHALL have port READ_DATA  out  32  load result, extended per funct3.
REQ-009 The block SHALL have port BUSY_WAIT  out  1  CPU stall request.
REQ-010 The block SHALL have ports MEM_READ and MEM_WRITE  out  1 each  memory-side block read and write strobes.
REQ-011 The block SHALL have port MEM_ADDRESS  out  28  block address (ADDRESS[31:4]).
REQ-012 The block SHALL have ports MEM_WRITE_DATA  out  128  and MEM_READ_DATA  in  128  carrying one block, word 0 in bits [31:0].
REQ-013 The block SHALL have port MEM_BUSY_WAIT  in  1  high while memory is serving a strobe.

Function
REQ-014 Organisation SHALL be direct-mapped, write-back, write-allocate, 4 words/line; offset = ADDRESS[3:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits; per line: valid, dirty, tag, 128-bit data.
REQ-015 Request = memReadEn[3] OR memWriteEn[2]; both high SHALL be treated as a store.
REQ-016 Hit = request AND valid[index] AND tag match; computed combinationally in IDLE.
REQ-017 Read hit: READ_DATA valid combinationally in the request cycle, BUSY_WAIT low; zero stall cycles.
REQ-018 Write hit: selected byte lanes updated and dirty set at the next CLK edge; BUSY_WAIT low.
REQ-019 Byte/half selection: byte lane = ADDRESS[1:0], half = ADDRESS[1]; ADDRESS[0] ignored for halves, ADDRESS[1:0] ignored for words; no misalignment trap.
REQ-020 LB/LH SHALL sign-extend, LBU/LHU zero-extend; READ_DATA SHALL be 0 when no load is requested.
REQ-021 BUSY_WAIT SHALL equal (request AND NOT hit in IDLE) OR (state != IDLE).
REQ-022 FSM states IDLE, WRITE_BACK, ALLOCATE, UPDATE.
REQ-023 IDLE -> WRITE_BACK on miss with dirty victim; IDLE -> ALLOCATE on miss with clean or invalid victim.
REQ-024 In WRITE_BACK: MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITE_DATA=victim block; -> ALLOCATE when MEM_BUSY_WAIT low.
REQ-025 In ALLOCATE: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4]; -> UPDATE when MEM_BUSY_WAIT low, latching MEM_READ_DATA.
REQ-026 UPDATE SHALL write the block, set valid, clear dirty, load tag, then return to IDLE, where the held request hits.
REQ-027 MEM_READ and MEM_WRITE SHALL never be high together and SHALL be low in IDLE and UPDATE.
REQ-028 The CPU holds request inputs stable while BUSY_WAIT is high; the block SHALL NOT latch them.

Reset
REQ-029 When RESET is high at a CLK edge: state IDLE, all valid and dirty bits 0, MEM_READ=0, MEM_WRITE=0, also when RESET arrives mid-miss; no write-back of dirty data.
REQ-030 After reset, MEM_ADDRESS=0, MEM_WRITE_DATA=0, and BUSY_WAIT follows REQ-021.

Structure
REQ-031 Encodings of memReadEn/memWriteEn, the FSM state enum, and the line and offset geometry constants SHALL live in a shared package (cache_pkg) reused by the instruction cache.
REQ-032 Load extraction and store byte-lane merge SHALL be one combinational sub-module, data_cache_align; the FSM and arrays stay in the top.

Verification
REQ-033 After reset, LW 0x0000_0040 with memory word 0x1234_5678 -> one WRITE_BACK-free miss, ALLOCATE then UPDATE, then READ_DATA=0x1234_5678 with BUSY_WAIT low.
REQ-034 SB 0xAB to 0x0000_0041, then LB 0x41 -> 0xFFFF_FFAB, LBU -> 0x0000_00AB, no stall on either.
REQ-035 With the line dirty, LW 0x0000_00C0 (same index, NUM_LINES=8) -> MEM_WRITE with MEM_ADDRESS=0x000_0004 and the merged block, then MEM_READ with 0x000_000C.
REQ-036 RESET asserted during ALLOCATE -> strobes low next edge; a repeated LW 0x40 misses again.
REQ-037 memReadEn and memWriteEn both high on a hit -> store performed, READ_DATA treated per REQ-015, dirty set.
REQ-038 MEM_BUSY_WAIT held high 5 cycles -> FSM waits, BUSY_WAIT stays high throughout, and MEM_ADDRESS stays stable.
